// File: rtl/qif_neuron_array.sv
// Time-multiplexed array of quadratic integrate-and-fire neurons: one shared
// update datapath visits the channels round-robin, one channel per enabled cycle.
module qif_neuron_array #(
  parameter int N_CH    = 4,
  parameter int W       = 8,
  parameter int SHIFT   = 4,
  parameter int LEAK    = 1,
  parameter int V_TH    = 200,
  parameter int V_RESET = 0,
  parameter int REFRAC  = 2,
  parameter int PW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_CH*W-1:0] b_in,
  input  logic [PW-1:0]     v_sel,
  output logic [W-1:0]      v_mon,
  output logic [N_CH-1:0]   spike_out,
  output logic              frame_done
);

  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam int SW = 2 * W + 2;

  localparam logic [SW-1:0] V_MAX   = {{(W + 2){1'b0}}, {W{1'b1}}};
  localparam logic [SW-1:0] VTH_S   = SW'(V_TH);
  localparam logic [SW-1:0] LEAK_S  = SW'(LEAK);
  localparam logic [W-1:0]  VRST    = W'(V_RESET);
  localparam logic [RW-1:0] RFR     = RW'(REFRAC);
  localparam logic [PW-1:0] LAST_CH = PW'(N_CH - 1);

  logic [W-1:0]  v_q    [N_CH];
  logic [RW-1:0] refr_q [N_CH];
  logic [PW-1:0] ptr;

  logic [W-1:0]   cur_v;
  logic [W-1:0]   cur_b;
  logic [RW-1:0]  cur_r;
  logic [2*W-1:0] sq;
  logic [SW-1:0]  sum;
  logic [SW-1:0]  s_raw;
  logic [SW-1:0]  s_sat;
  logic [W-1:0]   next_v;
  logic [RW-1:0]  next_r;
  logic           fire;

  // Shared update datapath for the channel under the pointer.
  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    cur_v  = v_q[ptr];
    cur_r  = refr_q[ptr];
    cur_b  = b_in[ptr*W +: W];
    sq     = {{W{1'b0}}, cur_v} * {{W{1'b0}}, cur_v};
    sum    = SW'(cur_v) + SW'(sq >> SHIFT) + SW'(cur_b);
    // sum < 2^(2W+1), so the top bit of the difference is a clean sign bit.
    s_raw  = sum - LEAK_S;
    s_sat  = s_raw;
    next_v = VRST;
    next_r = '0;
    fire   = 1'b0;

    if (s_raw[SW-1]) begin
      s_sat = '0;
    end else if (s_raw > V_MAX) begin
      s_sat = V_MAX;
    end

    if (cur_r != '0) begin
      next_v = VRST;
      next_r = cur_r - 1'b1;
    end else if (s_sat >= VTH_S) begin
      fire   = 1'b1;
      next_v = VRST;
      next_r = RFR;
    end else begin
      next_v = s_sat[W-1:0];
      next_r = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every process sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the per-channel arrays are reset because a fresh round must start from V=0, refr=0.
      for (int i = 0; i < N_CH; i++) begin
        v_q[i]    <= '0;
        refr_q[i] <= '0;
      end
      ptr        <= '0;
      spike_out  <= '0;
      frame_done <= 1'b0;
      v_mon      <= '0;
    end else begin
      spike_out  <= '0;
      frame_done <= 1'b0;
      v_mon      <= (int'(v_sel) < N_CH) ? v_q[v_sel] : '0;
      if (en) begin
        v_q[ptr]       <= next_v;
        refr_q[ptr]    <= next_r;
        spike_out[ptr] <= fire;
        frame_done     <= (ptr == LAST_CH);
        ptr            <= (ptr == LAST_CH) ? '0 : ptr + 1'b1;
      end
    end
  end

endmodule

// File: doc/qif_neuron_array.md
# qif_neuron_array

Parametrised, time-multiplexed array of quadratic integrate-and-fire (QIF) neurons. It is the multi-channel successor to the single-neuron QIF core. One shared update datapath serves N_CH channels in round-robin order, each with its own membrane register and refractory counter. The block sits between the chip I/O wrapper, which drives packed per-channel input currents, and the spike/monitor outputs.

## Interface
- N_CH, 4: number of neuron channels (≥2).
- W, 8: membrane and input-current width (unsigned).
- SHIFT, 4: right-shift applied to the V*V quadratic term.
- LEAK, 1: constant subtracted on every update.
- V_TH, 200: spike threshold; spike fires when V_next ≥ V_TH.
- V_RESET, 0: membrane value after a spike and during refractory.
- REFRAC, 2: number of a channel's own update slots spent refractory after a spike.
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  update enable; when low, the array is frozen.
- b_in  input  N_CH*W  packed input currents; channel k uses b_in[k*W +: W].
- v_sel  input  clog2(N_CH)  channel to monitor.
- v_mon  output  W  registered membrane value of channel v_sel.
- spike_out  output  N_CH  one-cycle spike pulse per channel.
- frame_done  output  1  one-cycle pulse after the last channel of a round is updated.

## Operation
- State:
  - V[0..N_CH-1] (W bits each).
  - refr[0..N_CH-1] (clog2(REFRAC+1) bits each).
  - Channel pointer ptr (clog2(N_CH) bits).
- Each rising edge with en=1: channel k=ptr is updated, then ptr advances (N_CH-1 wraps to 0). All other channels hold.
- If refr[k]>0: V[k]←V_RESET, refr[k]←refr[k]-1, b_in[k] is ignored, and no spike fires.
- Otherwise: S = V + ((V*V)>>SHIFT) + B − LEAK.
  - S is computed at 2W+2 bits.
  - If S<0, S is floored to 0. If S>2^W−1, S saturates to 2^W−1.
  - If S ≥ V_TH: spike_out[k]=1 next cycle, V[k]←V_RESET, refr[k]←REFRAC.
  - Else: V[k]←S.
- The threshold compare uses the saturated S.
- en=0: ptr, V and refr hold. spike_out and frame_done are 0 on the following cycle.
- v_mon←V[v_sel] every cycle regardless of en. It shows the post-edge register contents.
- rst (priority over en), all cleared on the next edge: V=0, refr=0, ptr=0, spike_out=0, frame_done=0, v_mon=0. Reset mid-round discards partial rounds; no spike is emitted for the aborted slot.

## Timing
- b_in[k] is sampled at the edge where ptr=k and en=1.
- spike_out[k] is registered. It is high exactly the one cycle after that edge and never high on two consecutive cycles for the same k.
- frame_done is high the cycle after the edge that updated channel N_CH−1.
- An update period per channel is N_CH enabled cycles. Gaps in en stretch the period but do not skip or repeat channels.
- v_mon latency: 1 cycle from a v_sel change or a V update.
- Spikes on different channels occur on distinct cycles. No simultaneous-spike arbitration is needed.
- Reset values: v_mon=0, spike_out=0, frame_done=0.

## Test plan
Defaults are used unless stated.
- **Reset:** rst high 2 cycles with arbitrary b_in → v_mon=0, spike_out=0, frame_done=0. The first enabled update after release is on ch0.
- **Quiescent:** b_in all 0, en=1, 64 cycles → every V stays 0 (leak floored), no spikes, frame_done pulses every 4 cycles.
- **Single channel firing:** b_in ch0=50, others 0 → V0 sequence 49, spike (49+150+49=248≥200), 0, 0 (refractory), 49, … spike_out[0] pulses every 16 cycles; other bits stay 0.
- **Saturation:** instance with V_TH=255, b_in ch1=255 → V1: 254, then S clipped to 255 → spike on the second ch1 slot, V1=0, refr=2.
- **Enable gating:** during the single-channel-firing stimulus, drop en for 5 cycles mid-round → ptr, V and v_mon are frozen and there are no pulses. The round resumes at the same channel, and the spike is delayed by exactly 5 cycles.
- **Reset mid-refractory:** assert rst while refr[0]=1 → after release, ch0 integrates from 0 immediately (first update = 49). There is no residual refractory period.
